multicycle_controller: RTL and testbench

Main control FSM of the multi-cycle MIPS CPU. It sequences every instruction through the fetch, decode, execute, memory and write-back states. In each state it drives the datapath enables and mux selects, and it produces the 4-bit `ALUOp` consumed directly by the ALU control decoder. It reads `OpCode`/`Funct` from the instruction register and holds no datapath state itself.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS CPU: IF/ID/EX/MEM/WB sequencing and datapath control.
// Define MC_LINK_EN to enable the jal/jalr link instructions; otherwise they execute as nops.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [2:0] State
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ST_W    = 3;
    localparam int unsigned ALUOP_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;
    localparam logic [OP_W-1:0] F_SLL    = 6'h00;
    localparam logic [OP_W-1:0] F_SRL    = 6'h02;
    localparam logic [OP_W-1:0] F_SRA    = 6'h03;
    localparam logic [OP_W-1:0] F_JR     = 6'h08;
    localparam logic [OP_W-1:0] F_JALR   = 6'h09;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_ADDIU = 4'b1011;
    localparam logic [ALUOP_W-1:0] ALU_ANDI  = 4'b1100;
    localparam logic [ALUOP_W-1:0] ALU_SLTI  = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_SLTIU = 4'b1101;

    typedef enum logic [ST_W-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_is_rtype, w_is_jr, w_is_jalr_f, w_is_shift, w_rtype_alu;
    logic w_is_lw, w_is_sw, w_is_beq, w_is_ialu, w_to_ex;
    logic w_link_jal, w_link_jalr;

    // Instruction decode from the IR fields
    assign w_is_rtype  = (OpCode == OP_RTYPE);
    assign w_is_jr     = w_is_rtype && (Funct == F_JR);
    assign w_is_jalr_f = w_is_rtype && (Funct == F_JALR);
    assign w_is_shift  = w_is_rtype && ((Funct == F_SLL) || (Funct == F_SRL) || (Funct == F_SRA));
    assign w_rtype_alu = w_is_rtype && !w_is_jr && !w_is_jalr_f;
    assign w_is_lw     = (OpCode == OP_LW);
    assign w_is_sw     = (OpCode == OP_SW);
    assign w_is_beq    = (OpCode == OP_BEQ);
    assign w_is_ialu   = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_ANDI) ||
                         (OpCode == OP_SLTI) || (OpCode == OP_SLTIU) || (OpCode == OP_LUI);
    assign w_to_ex     = w_rtype_alu || w_is_lw || w_is_sw || w_is_beq || w_is_ialu;

`ifdef MC_LINK_EN
    localparam logic [OP_W-1:0] OP_JAL = 6'h03;
    assign w_link_jal  = (OpCode == OP_JAL);
    assign w_link_jalr = w_is_jalr_f;
`else
    assign w_link_jal  = 1'b0;
    assign w_link_jalr = 1'b0;
`endif

    // Immediate handling depends on the opcode only, even under reset
    assign ExtOp = (OpCode != OP_ANDI);
    assign LuiOp = (OpCode == OP_LUI);
    assign State = ST_W'(r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IF;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 2'b00;
        RegDst       = 2'b00;
        RegWrite     = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = ALU_ADD;
        PCSource     = 2'b00;
        case (r_state)
            S_IF: begin
                MemRead      = 1'b1;
                IRWrite      = 1'b1;
                PCWrite      = 1'b1;
                ALUSrcB      = 2'b01;
                w_next_state = S_ID;
            end
            S_ID: begin
                // Branch target is computed speculatively into ALUOut
                ALUSrcB = 2'b11;
                if (OpCode == OP_J) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end else if (w_is_jr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end else if (w_link_jal) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end else if (w_link_jalr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                end else if (w_to_ex) begin
                    w_next_state = S_EX;
                end
            end
            S_EX: begin
                if (w_rtype_alu) begin
                    ALUSrcA      = w_is_shift ? 2'b10 : 2'b01;
                    ALUOp        = ALU_RTYPE;
                    w_next_state = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b10;
                    w_next_state = S_MEM;
                end else if (w_is_beq) begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end else if (w_is_ialu) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    case (OpCode)
                        OP_ADDIU: ALUOp = ALU_ADDIU;
                        OP_ANDI:  ALUOp = ALU_ANDI;
                        OP_SLTI:  ALUOp = ALU_SLTI;
                        OP_SLTIU: ALUOp = ALU_SLTIU;
                        default:  ALUOp = ALU_ADD;
                    endcase
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                IorD = 1'b1;
                if (w_is_lw) begin
                    MemRead      = 1'b1;
                    w_next_state = S_WB;
                end else if (w_is_sw) begin
                    MemWrite = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (w_is_lw) begin
                    MemtoReg = 2'b01;
                end else if (w_rtype_alu) begin
                    RegDst = 2'b01;
                end
            end
            default: w_next_state = S_IF;
        endcase
        // Reset kills every enable and select in the same cycle it rises
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 2'b00;
            RegDst      = 2'b00;
            RegWrite    = 1'b0;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = ALU_ADD;
            PCSource    = 2'b00;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized instruction
// streams and reset injection, checked against an instruction-class reference model.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] State;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef MC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw;
        logic [1:0] m2r, rd;
        logic       rw, ext, lui;
        logic [1:0] asa, asb;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic [2:0] st;
    } ov_t;

    typedef enum int {C_NOP, C_J, C_JR, C_JAL, C_JALR, C_BEQ, C_R, C_LW, C_SW, C_I} cls_t;

    ov_t dut_v;
    assign dut_v = ov_t'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                          RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, State});

    ov_t obs[8];
    int  obs_n;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .State(State)
    );

    always #5 clk = ~clk;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'h00:   return (f == 6'h08) ? C_JR : (f == 6'h09) ? (LINK ? C_JALR : C_NOP) : C_R;
            6'h02:   return C_J;
            6'h03:   return LINK ? C_JAL : C_NOP;
            6'h04:   return C_BEQ;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return C_I;
            default: return C_NOP;
        endcase
    endfunction

    function automatic int model_len(input logic [5:0] op, input logic [5:0] f);
        case (classify(op, f))
            C_BEQ:           return 3;
            C_R, C_SW, C_I:  return 4;
            C_LW:            return 5;
            default:         return 2;
        endcase
    endfunction

    // Output vector while reset is held: only State and the immediate controls survive
    function automatic ov_t model_rst(input logic [5:0] op, input logic [2:0] st);
        ov_t o = '0;
        o.ext = (op != 6'h0c);
        o.lui = (op == 6'h0f);
        o.st  = st;
        return o;
    endfunction

    // Expected outputs on the k-th cycle of an instruction (k = 0 is fetch)
    function automatic ov_t model(input logic [5:0] op, input logic [5:0] f, input int k);
        cls_t c = classify(op, f);
        ov_t  o = model_rst(op, 3'd0);
        if (k == 0) begin
            o.pcw = 1; o.mr = 1; o.irw = 1; o.asb = 2'b01;
        end else if (k == 1) begin
            o.st = 3'd1; o.asb = 2'b11;
            if (c inside {C_J, C_JR, C_JAL, C_JALR}) o.pcw = 1;
            if (c == C_J || c == C_JAL)   o.pcs = 2'b10;
            if (c == C_JR || c == C_JALR) o.pcs = 2'b11;
            if (c == C_JAL)  begin o.rw = 1; o.rd = 2'b10; o.m2r = 2'b10; end
            if (c == C_JALR) begin o.rw = 1; o.rd = 2'b01; o.m2r = 2'b10; end
        end else if (k == 2) begin
            o.st = 3'd2; o.asa = 2'b01;
            case (c)
                C_R: begin
                    o.alu = 4'b0010;
                    if (f == 6'h00 || f == 6'h02 || f == 6'h03) o.asa = 2'b10;
                end
                C_LW, C_SW: o.asb = 2'b10;
                C_BEQ: begin o.alu = 4'b0001; o.pcwc = 1; o.pcs = 2'b01; end
                default: begin
                    o.asb = 2'b10;
                    o.alu = (op == 6'h09) ? 4'b1011 : (op == 6'h0c) ? 4'b1100 :
                            (op == 6'h0a) ? 4'b0101 : (op == 6'h0b) ? 4'b1101 : 4'b0000;
                end
            endcase
        end else if (c == C_LW || c == C_SW) begin
            if (k == 3) begin
                o.st = 3'd3; o.iord = 1;
                if (c == C_LW) o.mr = 1; else o.mw = 1;
            end else begin
                o.st = 3'd4; o.rw = 1; o.m2r = 2'b01;
            end
        end else begin
            o.st = 3'd4; o.rw = 1;
            if (c == C_R) o.rd = 2'b01;
        end
        return o;
    endfunction

    // Run one instruction from IF back to IF, capturing outputs each cycle (bounded)
    task automatic exec(input logic [5:0] op, input logic [5:0] f);
        obs_n = 0;
        OpCode = 6'($urandom);
        Funct  = 6'($urandom);
        #1;
        OpCode = op;
        Funct  = f;
        do begin
            @(negedge clk);
            obs[obs_n] = dut_v;
            obs_n++;
            @(posedge clk);
            #1;
        end while (State != 3'd0 && obs_n < 8);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        OpCode = 6'h23;
        Funct  = 6'h00;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_v !== model_rst(6'h23, 3'd0)) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, 26'(dut_v), 26'(model_rst(6'h23, 3'd0)));
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exec(6'h23, 6'h00);
        n_cmp++;
        if (obs_n !== 5) begin
            n_bad++;
            $display("FAIL reset_lw_len got=%0d exp=5", obs_n);
        end
        for (int k = 0; k < obs_n && k < 5; k++) begin
            n_cmp++;
            if (obs[k] !== model(6'h23, 6'h00, k)) begin
                n_bad++;
                $display("FAIL reset_lw k=%0d got=%h exp=%h", k, 26'(obs[k]), 26'(model(6'h23, 6'h00, k)));
            end
        end
    endtask

    task automatic test_directed;
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h23, 6'h04, 6'h0b, 6'h0c, 6'h03, 6'h00, 6'h02, 6'h00};
        logic [5:0] fns [10] = '{6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h00, 6'h08};
        for (int t = 0; t < 10; t++) begin
            exec(ops[t], fns[t]);
            n_cmp++;
            if (obs_n !== model_len(ops[t], fns[t])) begin
                n_bad++;
                $display("FAIL dir_len op=%h f=%h got=%0d exp=%0d", ops[t], fns[t], obs_n, model_len(ops[t], fns[t]));
            end
            for (int k = 0; k < obs_n && k < model_len(ops[t], fns[t]); k++) begin
                n_cmp++;
                if (obs[k] !== model(ops[t], fns[t], k)) begin
                    n_bad++;
                    $display("FAIL dir op=%h f=%h k=%0d got=%h exp=%h", ops[t], fns[t], k,
                             26'(obs[k]), 26'(model(ops[t], fns[t], k)));
                end
            end
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] pool [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
                                  6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h00};
        int i = int'($urandom_range(0, 13));
        return (i == 13) ? 6'($urandom) : pool[i];
    endfunction

    function automatic logic [5:0] rand_fn();
        logic [5:0] pool [9] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h21, 6'h20, 6'h22, 6'h2a};
        int i = int'($urandom_range(0, 9));
        return (i == 9) ? 6'($urandom) : pool[i];
    endfunction

    task automatic test_random;
        logic [5:0] op, f;
        for (int t = 0; t < 80; t++) begin
            op = rand_op();
            f  = rand_fn();
            exec(op, f);
            n_cmp++;
            if (obs_n !== model_len(op, f)) begin
                n_bad++;
                $display("FAIL rnd_len op=%h f=%h got=%0d exp=%0d", op, f, obs_n, model_len(op, f));
            end
            for (int k = 0; k < obs_n && k < model_len(op, f); k++) begin
                n_cmp++;
                if (obs[k] !== model(op, f, k)) begin
                    n_bad++;
                    $display("FAIL rnd op=%h f=%h k=%0d got=%h exp=%h", op, f, k, 26'(obs[k]), 26'(model(op, f, k)));
                end
            end
        end
    endtask

    // Raise reset on cycle s of an instruction; sw in MEM is the first case
    task automatic test_reset_mid;
        logic [5:0] op, f;
        int         s;
        ov_t        e;
        for (int t = 0; t < 16; t++) begin
            op = (t == 0) ? 6'h2b : rand_op();
            f  = rand_fn();
            s  = (t == 0) ? 3 : int'($urandom_range(0, model_len(op, f) - 1));
            OpCode = op;
            Funct  = f;
            for (int k = 0; k < s; k++) begin
                @(negedge clk);
                n_cmp++;
                if (dut_v !== model(op, f, k)) begin
                    n_bad++;
                    $display("FAIL mid_pre op=%h k=%0d got=%h exp=%h", op, k, 26'(dut_v), 26'(model(op, f, k)));
                end
                @(posedge clk); #1;
            end
            reset = 1'b1;
            e = model_rst(op, model(op, f, s).st);
            @(negedge clk);
            n_cmp++;
            if (dut_v !== e) begin
                n_bad++;
                $display("FAIL mid_abort op=%h s=%0d got=%h exp=%h", op, s, 26'(dut_v), 26'(e));
            end
            for (int h = 0; h < 2; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                n_cmp++;
                if (dut_v !== model_rst(op, 3'd0)) begin
                    n_bad++;
                    $display("FAIL mid_hold op=%h h=%0d got=%h exp=%h", op, h, 26'(dut_v), 26'(model_rst(op, 3'd0)));
                end
            end
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (dut_v !== model(op, f, 0)) begin
                n_bad++;
                $display("FAIL mid_release op=%h got=%h exp=%h", op, 26'(dut_v), 26'(model(op, f, 0)));
            end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        reset  = 1'b1;
        OpCode = 6'h00;
        Funct  = 6'h00;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
